// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised VGA timing and test-pattern generator.
//
// Counts pixel clocks (h_cnt) and lines (v_cnt) in the order sync, back
// porch, active, front porch, and drives the DAC with registered,
// mutually aligned sync/blank/colour outputs. Pixel coordinates and a
// frame-start strobe are exported for downstream pixel sources.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   en           run enable; low clears and holds the counters, outputs idle
//   mode[1:0]    pattern: 0 solid, 1 colour bars, 2 grey ramp, 3 checkerboard
//   solid_rgb    colour used by mode 0
//   vga_rgb      pixel colour, [7:0] R, [15:8] G, [23:16] B
//   vga_hs/vs    syncs, active level set by HS_POL/VS_POL
//   vga_blank_n  high in the active region only
//   pix_x/pix_y  active-area coordinates, 0 outside the active region
//   pix_valid    copy of vga_blank_n
//   frame_start  one-cycle pulse for h_cnt=0, v_cnt=0
//
// Build option: define VGA_TG_BORDER_EN to paint a one-pixel white border
// around the active area, overriding every pattern.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [23:0]      solid_rgb,
  output logic [23:0]      vga_rgb,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_valid,
  output logic             frame_start
);

  localparam int H_TOT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int BAR_W = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SYN_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_ACT_BEG = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic             HS_ACT    = (HS_POL != 0);
  localparam logic             VS_ACT    = (VS_POL != 0);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             active;
  logic [CNT_W-1:0] x_c, y_c;
  logic [3:0]       bar_idx;
  logic [23:0]      bar_rgb, rgb_c;
  int               x_int;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // Pattern select only changes at the frame origin so a frame never tears.
  assign mode_d = (en && h_cnt_q == '0 && v_cnt_q == '0) ? mode : mode_q;

  assign active = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END) &&
                  (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
  assign x_c    = active ? h_cnt_q - H_ACT_BEG : '0;
  assign y_c    = active ? v_cnt_q - V_ACT_BEG : '0;
  assign x_int  = int'(x_c);

  // Bar index = number of whole bar widths already passed; columns past
  // the eighth bar (integer remainder) fall into the black default.
  always_comb begin
    bar_idx = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      if (x_int >= k * BAR_W) bar_idx = bar_idx + 4'd1;
    end
    case (bar_idx)
      4'd0:    bar_rgb = 24'hFFFFFF;
      4'd1:    bar_rgb = 24'h00FFFF;
      4'd2:    bar_rgb = 24'hFFFF00;
      4'd3:    bar_rgb = 24'h00FF00;
      4'd4:    bar_rgb = 24'hFF00FF;
      4'd5:    bar_rgb = 24'h0000FF;
      4'd6:    bar_rgb = 24'hFF0000;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    rgb_c = '0;
    if (active) begin
      case (mode_q)
        2'd0:    rgb_c = solid_rgb;
        2'd1:    rgb_c = bar_rgb;
        2'd2:    rgb_c = {3{x_c[7:0]}};
        default: rgb_c = (x_c[5] ^ y_c[5]) ? 24'hFFFFFF : 24'h000000;
      endcase
`ifdef VGA_TG_BORDER_EN
      if (x_c == '0 || x_c == CNT_W'(H_ACTIVE - 1) ||
          y_c == '0 || y_c == CNT_W'(V_ACTIVE - 1)) begin
        rgb_c = 24'hFFFFFF;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      mode_q  <= 2'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      mode_q  <= mode_d;
    end
  end

  // All video outputs come from the same counter state, one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb     <= '0;
      vga_hs      <= ~HS_ACT;
      vga_vs      <= ~VS_ACT;
      vga_blank_n <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      vga_rgb     <= '0;
      vga_hs      <= ~HS_ACT;
      vga_vs      <= ~VS_ACT;
      vga_blank_n <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_rgb     <= rgb_c;
      vga_hs      <= (h_cnt_q < H_SYN_END) ? HS_ACT : ~HS_ACT;
      vga_vs      <= (v_cnt_q < V_SYN_END) ? VS_ACT : ~VS_ACT;
      vga_blank_n <= active;
      pix_x       <= x_c;
      pix_y       <= y_c;
      frame_start <= (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  assign pix_valid = vga_blank_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Main instance: standard 640-wide line, shortened frame so several
  // frames fit in a short run.
  localparam int M_HT  = 800;
  localparam int M_HA0 = 144;
  localparam int M_HA  = 640;
  localparam int M_VT  = 37;
  localparam int M_VA0 = 3;
  localparam int M_VA  = 33;
  localparam int M_FR  = M_HT * M_VT;

`ifdef VGA_TG_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        pv;
    logic [11:0] px;
    logic [11:0] py;
    logic        fs;
  } obs_t;

  typedef struct {
    int          fr;
    int          y;
    int          x;
    int          set_mode;
    logic [23:0] rgb;
  } vec_t;

  logic        clk, rst_n, en;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic [23:0] vga_rgb;
  logic        vga_hs, vga_vs, vga_blank_n, pix_valid, frame_start;
  logic [11:0] pix_x, pix_y;

  logic [1:0]  b_mode;
  logic [23:0] b_solid, b_rgb;
  logic        b_hs, b_vs, b_blank_n, b_valid, b_fs;
  logic [11:0] b_x, b_y;

  int n_tests = 0;
  int n_fail  = 0;
  int kc      = 0;

  vga_timing_gen #(
    .H_SYNC(96), .H_BACK(48), .H_ACTIVE(640), .H_FRONT(16),
    .V_SYNC(2), .V_BACK(1), .V_ACTIVE(33), .V_FRONT(1),
    .HS_POL(0), .VS_POL(0), .CNT_W(12)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .vga_rgb(vga_rgb), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .frame_start(frame_start)
  );

  // 800-wide, positive-polarity instance running the grey ramp.
  vga_timing_gen #(
    .H_SYNC(128), .H_BACK(88), .H_ACTIVE(800), .H_FRONT(40),
    .V_SYNC(4), .V_BACK(2), .V_ACTIVE(3), .V_FRONT(1),
    .HS_POL(1), .VS_POL(1), .CNT_W(12)
  ) u_pos (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(b_mode), .solid_rgb(b_solid),
    .vga_rgb(b_rgb), .vga_hs(b_hs), .vga_vs(b_vs),
    .vga_blank_n(b_blank_n), .pix_x(b_x), .pix_y(b_y),
    .pix_valid(b_valid), .frame_start(b_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    kc++;
  endtask

  task automatic wait_k(input int n);
    while (kc < n) step();
  endtask

  function automatic logic [23:0] with_border(input int x, input int y, input logic [23:0] c);
    logic on_rim;
    on_rim = (x == 0) || (x == M_HA - 1) || (y == 0) || (y == M_VA - 1);
    return (BORDER && on_rim) ? 24'hFFFFFF : c;
  endfunction

  function automatic logic [23:0] bar_of(input int px);
    case (px / (M_HA / 8))
      0: return 24'hFFFFFF;
      1: return 24'h00FFFF;
      2: return 24'hFFFF00;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'h0000FF;
      6: return 24'hFF0000;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic obs_t idle_out();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  function automatic obs_t model_out(input int h, input int v, input logic [1:0] m,
                                     input logic [23:0] solid);
    obs_t o;
    int px, py;
    o = '0;
    o.hs = (h < 96) ? 1'b0 : 1'b1;
    o.vs = (v < 2) ? 1'b0 : 1'b1;
    o.fs = (h == 0) && (v == 0);
    if (h >= M_HA0 && h < M_HA0 + M_HA && v >= M_VA0 && v < M_VA0 + M_VA) begin
      px = h - M_HA0;
      py = v - M_VA0;
      o.blank = 1'b1;
      o.pv    = 1'b1;
      o.px    = 12'(px);
      o.py    = 12'(py);
      case (m)
        2'd0:    o.rgb = solid;
        2'd1:    o.rgb = bar_of(px);
        2'd2:    o.rgb = {3{o.px[7:0]}};
        default: o.rgb = ((((px / 32) ^ (py / 32)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      endcase
      o.rgb = with_border(px, py, o.rgb);
    end
    return o;
  endfunction

  // Scoreboard: expected outputs pushed when the inputs are clocked in,
  // popped and compared half a cycle later. Mismatches are tallied over
  // windows of one line length, one comparison per window.
  obs_t       sb_q[$];
  int         mh = 0, mv = 0;
  logic [1:0] mm = 2'd0;
  int         win_n = 0, win_err = 0;
  obs_t       first_a, first_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh = 0;
      mv = 0;
      mm = 2'd0;
      sb_q.delete();
    end else if (!en) begin
      sb_q.push_back(idle_out());
      mh = 0;
      mv = 0;
    end else begin
      sb_q.push_back(model_out(mh, mv, mm, solid_rgb));
      if (mh == 0 && mv == 0) mm = mode;
      if (mh == M_HT - 1) begin
        mh = 0;
        mv = (mv == M_VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  end

  task automatic sb_close();
    n_tests++;
    if (win_err != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d mismatching cycles, first got %h expected %h",
               win_err, first_a, first_e);
    end
    win_n   = 0;
    win_err = 0;
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = {vga_rgb, vga_hs, vga_vs, vga_blank_n, pix_valid, pix_x, pix_y, frame_start};
      if (a !== e) begin
        if (win_err == 0) begin
          first_a = a;
          first_e = e;
        end
        win_err++;
      end
      win_n++;
      if (win_n == M_HT) sb_close();
    end
  end

  int fs_k[2] = '{-1, -1};
  int fs_n = 0;
  always @(negedge clk) begin
    if (rst_n && frame_start && fs_n < 2) begin
      fs_k[fs_n] = kc;
      fs_n++;
    end
  end

  vec_t vt[16];

  initial begin
    int hs_lo, vs_lo, bhs_hi, r1, r2, cnt, tk;
    logic b_prev;

    // checker frame, mode switched to bars at y=20, bars in next frame
    vt[0]  = '{0, 10,   0, -1, 24'h000000};
    vt[1]  = '{0, 10,  32, -1, 24'hFFFFFF};
    vt[2]  = '{0, 20, 100,  1, 24'hFFFFFF};
    vt[3]  = '{0, 25,  40, -1, 24'hFFFFFF};
    vt[4]  = '{0, 32,   0, -1, 24'hFFFFFF};
    vt[5]  = '{0, 32,  32, -1, 24'h000000};
    vt[6]  = '{1, 10,   0, -1, 24'hFFFFFF};
    vt[7]  = '{1, 10,  79, -1, 24'hFFFFFF};
    vt[8]  = '{1, 10,  80, -1, 24'h00FFFF};
    vt[9]  = '{1, 10, 160, -1, 24'hFFFF00};
    vt[10] = '{1, 10, 240, -1, 24'h00FF00};
    vt[11] = '{1, 10, 320, -1, 24'hFF00FF};
    vt[12] = '{1, 10, 400, -1, 24'h0000FF};
    vt[13] = '{1, 10, 480, -1, 24'hFF0000};
    vt[14] = '{1, 10, 560, -1, 24'h000000};
    vt[15] = '{1, 10, 639, -1, 24'h000000};

    rst_n = 1'b0;
    en = 1'b0;
    mode = 2'd3;
    solid_rgb = 24'h123456;
    b_mode = 2'd2;
    b_solid = 24'h0;
    step();
    step();
    chk("reset hs", 32'(vga_hs), 32'd1);
    chk("reset vs", 32'(vga_vs), 32'd1);
    chk("reset blank_n", 32'(vga_blank_n), 32'd0);
    chk("reset rgb", 32'(vga_rgb), 32'd0);
    chk("reset frame_start", 32'(frame_start), 32'd0);
    chk("reset pos hs", 32'(b_hs), 32'd0);
    chk("reset pos vs", 32'(b_vs), 32'd0);

    rst_n = 1'b1;
    repeat (3) step();
    chk("idle hs", 32'(vga_hs), 32'd1);

    en = 1'b1;
    kc = 0;
    hs_lo = 0; vs_lo = 0; bhs_hi = 0; r1 = -1; r2 = -1;
    b_prev = b_hs;
    for (int i = 0; i < 2400; i++) begin
      step();
      if (kc == 1) chk("first frame_start", 32'(frame_start), 32'd1);
      if (kc == 2) chk("frame_start width", 32'(frame_start), 32'd0);
      if (kc <= M_HT && !vga_hs) hs_lo++;
      if (!vga_vs) vs_lo++;
      if (kc <= 1056 && b_hs) bhs_hi++;
      if (b_hs && !b_prev) begin
        if (r1 < 0) r1 = kc;
        else if (r2 < 0) r2 = kc;
      end
      b_prev = b_hs;
    end
    chk("hs low per line", 32'(hs_lo), 32'd96);
    chk("vs low per frame", 32'(vs_lo), 32'd1600);
    chk("pos hs high per line", 32'(bhs_hi), 32'd128);
    chk("pos line length", 32'(r2 - r1), 32'd1056);

    wait_k(4224);
    chk("pos vs last sync line", 32'(b_vs), 32'd1);
    step();
    chk("pos vs after sync", 32'(b_vs), 32'd0);
    wait_k(7909);
    chk("pos ramp x300", 32'(b_rgb), 32'h2C2C2C);
    chk("pos ramp blank_n", 32'(b_blank_n), 32'd1);

    wait_k(12 * M_HT);
    cnt = 0;
    for (int i = 0; i < M_HT; i++) begin
      step();
      if (vga_blank_n) cnt++;
    end
    chk("blank_n high per line f0", 32'(cnt), 32'd640);

    for (int i = 0; i < 16; i++) begin
      tk = vt[i].fr * M_FR + (vt[i].y + M_VA0) * M_HT + M_HA0 + vt[i].x + 1;
      wait_k(tk);
      chk($sformatf("vec%0d rgb", i), 32'(vga_rgb),
          32'(with_border(vt[i].x, vt[i].y, vt[i].rgb)));
      chk($sformatf("vec%0d pix_x", i), 32'(pix_x), 32'(vt[i].x));
      chk($sformatf("vec%0d pix_y", i), 32'(pix_y), 32'(vt[i].y));
      if (vt[i].set_mode >= 0) mode = 2'(vt[i].set_mode);
    end

    chk("frame_start count", 32'(fs_n), 32'd2);
    chk("frame_start first k", 32'(fs_k[0]), 32'd1);
    chk("frame period", 32'(fs_k[1] - fs_k[0]), 32'(M_FR));

    wait_k(M_FR + 14 * M_HT);
    cnt = 0;
    for (int i = 0; i < M_HT; i++) begin
      step();
      if (vga_blank_n) cnt++;
    end
    chk("blank_n high per line f1", 32'(cnt), 32'd640);

    // drop en while h_cnt=300 on an active line
    wait_k(M_FR + 16 * M_HT + 300);
    chk("pre-drop blank_n", 32'(vga_blank_n), 32'd1);
    en = 1'b0;
    step();
    chk("en low blank_n", 32'(vga_blank_n), 32'd0);
    chk("en low hs", 32'(vga_hs), 32'd1);
    chk("en low vs", 32'(vga_vs), 32'd1);
    chk("en low rgb", 32'(vga_rgb), 32'd0);
    chk("en low pix_x", 32'(pix_x), 32'd0);

    mode = 2'd0;
    solid_rgb = 24'h0000FF;
    repeat (3) step();
    en = 1'b1;
    kc = 0;
    step();
    chk("restart frame_start", 32'(frame_start), 32'd1);
    step();
    chk("restart frame_start width", 32'(frame_start), 32'd0);
    wait_k(3 * M_HT + M_HA0);
    chk("before first pixel blank_n", 32'(vga_blank_n), 32'd0);
    step();
    chk("first pixel blank_n", 32'(vga_blank_n), 32'd1);
    chk("first pixel pix_x", 32'(pix_x), 32'd0);
    chk("first pixel pix_y", 32'(pix_y), 32'd0);
    chk("first pixel rgb", 32'(vga_rgb), 32'(with_border(0, 0, 24'h0000FF)));
`ifdef VGA_TG_BORDER_EN
    wait_k(3 * M_HT + M_HA0 + 639 + 1);
    chk("border top-right", 32'(vga_rgb), 32'hFFFFFF);
`endif
    wait_k(4 * M_HT + M_HA0 + 1 + 1);
    chk("solid pixel 1,1", 32'(vga_rgb), 32'h0000FF);

    // asynchronous reset between clock edges
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset rgb", 32'(vga_rgb), 32'd0);
    chk("async reset blank_n", 32'(vga_blank_n), 32'd0);
    chk("async reset hs", 32'(vga_hs), 32'd1);
    chk("async reset pix_x", 32'(pix_x), 32'd0);
    chk("async reset pos hs", 32'(b_hs), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    if (win_n > 0) sb_close();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing and test-pattern generator driving the board DAC (24-bit RGB, HS, VS, BLANK_N). Successor to the fixed 640x480@60 stripe generator: every timing field and sync polarity is a parameter, four selectable patterns are provided, and all video outputs are pipeline-aligned. It also exports pixel coordinates and a frame-start strobe so downstream pixel sources can be synchronised to it.

## Interface
- H_SYNC, 96, horizontal sync width (pixel clocks)
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, horizontal active pixels
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, vertical active lines
- V_FRONT, 10, vertical front porch
- HS_POL, 0, HS active level (0 = active-low)
- VS_POL, 0, VS active level (0 = active-low)
- CNT_W, 12, counter and coordinate width; must hold H and V totals

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run enable; 0 holds generator idle
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 grey ramp, 3 checkerboard
- solid_rgb  in  24  colour for mode 0
- vga_rgb  out  24  pixel colour; [7:0] R, [15:8] G, [23:16] B
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_blank_n  out  1  high in active region only
- pix_x  out  CNT_W  active-area column, 0 outside active
- pix_y  out  CNT_W  active-area row, 0 outside active
- pix_valid  out  1  equals vga_blank_n
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0

## Operation
- H_TOT = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOT likewise. Line order: sync, back porch, active, front porch.
- h_cnt counts 0..H_TOT-1 and wraps to 0; v_cnt increments when h_cnt wraps, counting 0..V_TOT-1 and wrapping to 0.
- HS active while h_cnt < H_SYNC; VS active while v_cnt < V_SYNC (whole lines). Active level = HS_POL/VS_POL; otherwise inverse.
- Active region: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE, with the same form for v_cnt. pix_x/pix_y = counter minus porch offset.
- mode is sampled into mode_q only when h_cnt=0 and v_cnt=0 (no mid-frame tearing). solid_rgb is sampled every pixel.
- Patterns (active region only; black elsewhere):
  - 0: solid_rgb.
  - 1: eight bars of width H_ACTIVE/8 (integer): white, yellow, cyan, green, magenta, red, blue, black. Remainder columns take black.
  - 2: R=G=B=pix_x[7:0].
  - 3: 0xFFFFFF if pix_x[5]^pix_y[5], else 0x000000.
- en=0: counters synchronously cleared to 0 and held; outputs take their idle values (reset values) one cycle later. en rising: counting restarts at h_cnt=0, v_cnt=0, so the first registered cycle issues frame_start.

## Timing
- Reset values: vga_hs=~HS_POL, vga_vs=~VS_POL, vga_blank_n=0, pix_valid=0, vga_rgb=0, pix_x=pix_y=0, frame_start=0, counters=0, mode_q=0.
- Outputs are registered with a latency of 1 clock from the counter state. Every output reflects the same counter value in the same cycle (sync, blank, rgb, coordinates and strobe are mutually aligned).
- First frame_start occurs 1 clock after the first rising clock edge with rst_n=1 and en=1. The period is then H_TOT*V_TOT clocks.
- mode_q change becomes visible on the first active pixel of the frame following the sampling point.
- Asserting rst_n low mid-frame forces all outputs to reset values immediately (asynchronously).

## Configuration
- VGA_TG_BORDER_EN defined: active pixels with pix_x==0, pix_x==H_ACTIVE-1, pix_y==0 or pix_y==V_ACTIVE-1 output 0xFFFFFF, overriding every mode. No added latency.
- VGA_TG_BORDER_EN undefined: pattern output only; no border logic.

## Test plan
- Reset then en=1, default params -> frame_start every 420000 clocks; HS low for 96 of every 800 clocks; VS low for 1600 clocks per frame.
- mode=1 -> on line pix_y=10, pix_x=0 gives 0xFFFFFF, pix_x=80 gives 0x00FFFF (yellow), pix_x=639 gives 0x000000; vga_blank_n high for exactly 640 clocks per active line.
- mode changed 0->3 at pix_y=200 -> current frame stays solid_rgb; next frame pix_x=32,pix_y=0 gives 0xFFFFFF and pix_x=32,pix_y=32 gives 0x000000.
- en dropped at h_cnt=300 -> one clock later blank_n=0, HS/VS inactive, rgb=0; en raised -> frame_start 1 clock later, pix_x=0 at 145th clock.
- HS_POL=1, VS_POL=1, 800x600 (H 128/88/800/40, V 4/23/600/1) -> HS high 128 clocks, line 1056 clocks, frame 628 lines.
- VGA_TG_BORDER_EN defined, mode=0, solid_rgb=0x0000FF -> corners and edges 0xFFFFFF, pixel (1,1) 0x0000FF.
